pc_sequencer: RTL and testbench

Next-PC controller for the MIPS pipeline. It owns the program counter register and picks each cycle's next PC from five sources: sequential PC+4, jump target, jump-register target, branch target and hold. It sits between the IF stage instruction memory address and the ID/EX redirect sources. It also generates the IF/ID and ID/EX flush strobes and sequences the halt drain so the debug unit can read final state.

---
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : next-PC selection, IF/ID and ID/EX flush strobes, halt drain
// Rev 1.0
// ============================================================================
module pc_sequencer #(
    parameter int                   BITS_SIZE    = 32,
    parameter logic [BITS_SIZE-1:0] RESET_PC     = '0,
    parameter int                   DRAIN_CYCLES = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_stall,
    input  logic                 i_halt,
    input  logic                 i_jump,
    input  logic [BITS_SIZE-1:0] i_jump_target,
    input  logic                 i_jr,
    input  logic [BITS_SIZE-1:0] i_jr_target,
    input  logic                 i_branch_taken,
    input  logic [BITS_SIZE-1:0] i_branch_target,
    output logic [BITS_SIZE-1:0] o_pc,
    output logic [BITS_SIZE-1:0] o_pc4,
    output logic                 o_flush_ifid,
    output logic                 o_flush_idex,
    output logic                 o_halted,
    output logic                 o_misaligned
);

    localparam int                   CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [BITS_SIZE-1:0] PC_STEP    = BITS_SIZE'(4);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BITS_SIZE-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 halted_q, halted_d;
    logic                 mis_q, mis_d;
    logic                 flush_ifid, flush_idex;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        halted_d   = halted_q;
        mis_d      = mis_q;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;

        if (i_enable) begin
            case (state_q)
                // IDLE advances exactly like RUN on its first enabled cycle
                ST_IDLE, ST_RUN: begin
                    state_d = ST_RUN;
                    if (i_branch_taken) begin
                        pc_d       = {i_branch_target[BITS_SIZE-1:2], 2'b00};
                        mis_d      = mis_q | (|i_branch_target[1:0]);
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else if (i_stall) begin
                        pc_d = pc_q;
                    end else if (i_halt) begin
                        flush_ifid = 1'b1;
                        state_d    = ST_DRAIN;
                        cnt_d      = DRAIN_LOAD;
                    end else if (i_jr) begin
                        pc_d       = {i_jr_target[BITS_SIZE-1:2], 2'b00};
                        mis_d      = mis_q | (|i_jr_target[1:0]);
                        flush_ifid = 1'b1;
                    end else if (i_jump) begin
                        pc_d       = {i_jump_target[BITS_SIZE-1:2], 2'b00};
                        mis_d      = mis_q | (|i_jump_target[1:0]);
                        flush_ifid = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
        end
    end

    // Strobes are suppressed under reset so no stale redirect clears a pipe stage
    assign o_flush_ifid = flush_ifid & ~i_reset;
    assign o_flush_idex = flush_idex & ~i_reset;
    assign o_pc         = pc_q;
    assign o_pc4        = pc_q + PC_STEP;
    assign o_halted     = halted_q;
    assign o_misaligned = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer : vector table, hand-written halt sequence, random vs model
// Rev 1.0
// ============================================================================
module tb_pc_sequencer;

    localparam int DRAIN_CYCLES = 3;

    typedef struct packed {
        logic        rst, en, stall, halt, jump;
        logic [31:0] jt;
        logic        jr;
        logic [31:0] jrt;
        logic        br;
        logic [31:0] bt;
        logic [31:0] pc;
        logic        fi, fe, hd, mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        i_reset, i_enable, i_stall, i_halt, i_jump, i_jr, i_branch_taken;
    logic [31:0] i_jump_target, i_jr_target, i_branch_target;
    logic [31:0] o_pc, o_pc4;
    logic        o_flush_ifid, o_flush_idex, o_halted, o_misaligned;

    int checks = 0;
    int errors = 0;

    // Reference model state: PC, drain countdown to o_halted, sticky flags
    logic [31:0] m_pc;
    logic        m_drain, m_halted, m_mis;
    int          m_left;

    pc_sequencer #(
        .BITS_SIZE   (32),
        .RESET_PC    (32'h0000_0000),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_stall        (i_stall),
        .i_halt         (i_halt),
        .i_jump         (i_jump),
        .i_jump_target  (i_jump_target),
        .i_jr           (i_jr),
        .i_jr_target    (i_jr_target),
        .i_branch_taken (i_branch_taken),
        .i_branch_target(i_branch_target),
        .o_pc           (o_pc),
        .o_pc4          (o_pc4),
        .o_flush_ifid   (o_flush_ifid),
        .o_flush_idex   (o_flush_idex),
        .o_halted       (o_halted),
        .o_misaligned   (o_misaligned)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic en, input logic stall, input logic halt,
                                input logic jump, input logic [31:0] jt, input logic jr, input logic [31:0] jrt,
                                input logic br, input logic [31:0] bt, input logic [31:0] pc,
                                input logic fi, input logic fe, input logic hd, input logic mis);
        vec_t v;
        v.rst = rst; v.en = en; v.stall = stall; v.halt = halt; v.jump = jump; v.jt = jt;
        v.jr = jr; v.jrt = jrt; v.br = br; v.bt = bt; v.pc = pc;
        v.fi = fi; v.fe = fe; v.hd = hd; v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // mode 0: compare against model, 1: compare against vector, 2: drive only
    task automatic step(input vec_t v, input int mode, input string tag);
        logic [31:0] n_pc;
        logic        n_drain, n_halted, n_mis, e_fi, e_fe;
        int          n_left;
        @(negedge clk);
        i_reset = v.rst; i_enable = v.en; i_stall = v.stall; i_halt = v.halt;
        i_jump = v.jump; i_jump_target = v.jt; i_jr = v.jr; i_jr_target = v.jrt;
        i_branch_taken = v.br; i_branch_target = v.bt;
        #1;
        n_pc = m_pc; n_drain = m_drain; n_halted = m_halted; n_mis = m_mis; n_left = m_left;
        e_fi = 1'b0; e_fe = 1'b0;
        if (v.rst) begin
            n_pc = 32'h0; n_drain = 1'b0; n_halted = 1'b0; n_mis = 1'b0; n_left = 0;
        end else if (v.en && !m_halted) begin
            if (m_drain) begin
                n_left = m_left - 1;
                if (n_left == 0) begin
                    n_drain  = 1'b0;
                    n_halted = 1'b1;
                end
            end else if (v.br) begin
                n_pc = v.bt & 32'hFFFF_FFFC; n_mis = m_mis | (v.bt[1:0] != 2'b00);
                e_fi = 1'b1; e_fe = 1'b1;
            end else if (v.stall) begin
                n_pc = m_pc;
            end else if (v.halt) begin
                e_fi = 1'b1; n_drain = 1'b1; n_left = DRAIN_CYCLES;
            end else if (v.jr) begin
                n_pc = v.jrt & 32'hFFFF_FFFC; n_mis = m_mis | (v.jrt[1:0] != 2'b00); e_fi = 1'b1;
            end else if (v.jump) begin
                n_pc = v.jt & 32'hFFFF_FFFC; n_mis = m_mis | (v.jt[1:0] != 2'b00); e_fi = 1'b1;
            end else begin
                n_pc = m_pc + 32'd4;
            end
        end
        if (mode == 0) begin
            chk({tag, " pc"}, o_pc, m_pc);
            chk({tag, " pc4"}, o_pc4, m_pc + 32'd4);
            chk({tag, " flush_ifid"}, {31'd0, o_flush_ifid}, {31'd0, e_fi});
            chk({tag, " flush_idex"}, {31'd0, o_flush_idex}, {31'd0, e_fe});
            chk({tag, " halted"}, {31'd0, o_halted}, {31'd0, m_halted});
            chk({tag, " misaligned"}, {31'd0, o_misaligned}, {31'd0, m_mis});
        end else if (mode == 1) begin
            chk({tag, " pc"}, o_pc, v.pc);
            chk({tag, " pc4"}, o_pc4, v.pc + 32'd4);
            chk({tag, " flush_ifid"}, {31'd0, o_flush_ifid}, {31'd0, v.fi});
            chk({tag, " flush_idex"}, {31'd0, o_flush_idex}, {31'd0, v.fe});
            chk({tag, " halted"}, {31'd0, o_halted}, {31'd0, v.hd});
            chk({tag, " misaligned"}, {31'd0, o_misaligned}, {31'd0, v.mis});
        end
        @(posedge clk);
        m_pc = n_pc; m_drain = n_drain; m_halted = n_halted; m_mis = n_mis; m_left = n_left;
    endtask

    vec_t tbl[21];
    vec_t rst_v, off_v, run_v, hv;

    initial begin
        m_pc = 32'h0; m_drain = 1'b0; m_halted = 1'b0; m_mis = 1'b0; m_left = 0;
        rst_v = mk(1,0,0,0, 0,0, 0,0, 0,0, 32'h0, 0,0,0,0);
        off_v = mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h0, 0,0,0,0);
        run_v = mk(0,1,0,0, 0,0, 0,0, 0,0, 32'h0, 0,0,0,0);

        tbl[0]  = mk(0,1,0,0, 0,0,            0,0,            0,0,     32'h0000_0000, 0,0,0,0);
        tbl[1]  = mk(0,1,0,0, 0,0,            0,0,            0,0,     32'h0000_0004, 0,0,0,0);
        tbl[2]  = mk(0,1,0,0, 0,0,            0,0,            0,0,     32'h0000_0008, 0,0,0,0);
        tbl[3]  = mk(0,1,0,0, 0,0,            0,0,            0,0,     32'h0000_000C, 0,0,0,0);
        tbl[4]  = mk(0,1,1,0, 0,0,            0,0,            0,0,     32'h0000_0010, 0,0,0,0);
        tbl[5]  = mk(0,1,1,0, 0,0,            0,0,            0,0,     32'h0000_0010, 0,0,0,0);
        tbl[6]  = mk(0,1,1,0, 0,0,            0,0,            0,0,     32'h0000_0010, 0,0,0,0);
        tbl[7]  = mk(0,1,0,0, 0,0,            0,0,            0,0,     32'h0000_0010, 0,0,0,0);
        tbl[8]  = mk(0,1,0,0, 0,0,            0,0,            0,0,     32'h0000_0014, 0,0,0,0);
        tbl[9]  = mk(0,1,0,0, 0,0,            0,0,            0,0,     32'h0000_0018, 0,0,0,0);
        tbl[10] = mk(0,1,0,0, 0,0,            0,0,            0,0,     32'h0000_001C, 0,0,0,0);
        tbl[11] = mk(0,1,0,0, 1,32'h100,      0,0,            0,0,     32'h0000_0020, 1,0,0,0);
        tbl[12] = mk(0,1,0,0, 0,0,            0,0,            0,0,     32'h0000_0100, 0,0,0,0);
        tbl[13] = mk(0,1,1,0, 1,32'h100,      0,0,            1,32'h40,32'h0000_0104, 1,1,0,0);
        tbl[14] = mk(0,0,0,0, 1,32'h100,      0,0,            0,0,     32'h0000_0040, 0,0,0,0);
        tbl[15] = mk(0,0,0,0, 0,0,            0,0,            1,32'h80,32'h0000_0040, 0,0,0,0);
        tbl[16] = mk(0,1,0,0, 1,32'h500,      1,32'h203,      0,0,     32'h0000_0040, 1,0,0,0);
        tbl[17] = mk(0,1,0,0, 0,0,            0,0,            0,0,     32'h0000_0200, 0,0,0,1);
        tbl[18] = mk(0,1,0,0, 1,32'hFFFF_FFFC,0,0,            0,0,     32'h0000_0204, 1,0,0,1);
        tbl[19] = mk(0,1,0,0, 0,0,            0,0,            0,0,     32'hFFFF_FFFC, 0,0,0,1);
        tbl[20] = mk(0,1,0,0, 0,0,            0,0,            0,0,     32'h0000_0000, 0,0,0,1);

        step(rst_v, 2, "reset");
        step(off_v, 1, "reset_state");
        for (int i = 0; i < 21; i++) step(tbl[i], 1, $sformatf("vec%0d", i));
        step(rst_v, 2, "reset");
        step(off_v, 1, "mis_cleared");

        // Halt drain: halt at 0x30, o_halted exactly DRAIN_CYCLES+1 cycles later
        step(rst_v, 2, "reset");
        for (int i = 0; i < 12; i++) begin
            hv = run_v; hv.pc = 32'(i * 4);
            step(hv, 1, $sformatf("pre_halt%0d", i));
        end
        hv = run_v; hv.halt = 1'b1; hv.pc = 32'h30; hv.fi = 1'b1;
        step(hv, 1, "halt");
        for (int k = 1; k <= DRAIN_CYCLES; k++) begin
            hv = run_v; hv.pc = 32'h30; hv.jump = (k == 2); hv.jt = 32'h400;
            hv.br = (k == 3); hv.bt = 32'h500;
            step(hv, 1, $sformatf("drain%0d", k));
        end
        hv = run_v; hv.pc = 32'h30; hv.hd = 1'b1;
        step(hv, 1, "halted");
        hv = run_v; hv.pc = 32'h30; hv.hd = 1'b1; hv.jump = 1'b1; hv.jt = 32'h100;
        step(hv, 1, "halted_jump");
        hv = off_v; hv.pc = 32'h30; hv.hd = 1'b1; hv.stall = 1'b1;
        step(hv, 1, "halted_off");
        step(rst_v, 2, "reset");
        step(off_v, 1, "post_halt_reset");

        // Randomized stimulus against the reference model
        step(rst_v, 2, "reset");
        for (int n = 0; n < 3000; n++) begin
            vec_t r;
            r = off_v;
            r.rst   = ($urandom_range(0, 49) == 0);
            r.en    = ($urandom_range(0, 7) != 0);
            r.stall = ($urandom_range(0, 5) == 0);
            r.halt  = ($urandom_range(0, 39) == 0);
            r.jump  = ($urandom_range(0, 7) == 0);
            r.jr    = ($urandom_range(0, 7) == 0);
            r.br    = ($urandom_range(0, 9) == 0);
            r.jt    = $urandom; r.jrt = $urandom; r.bt = $urandom;
            if ($urandom_range(0, 3) != 0) r.jt[1:0]  = 2'b00;
            if ($urandom_range(0, 3) != 0) r.jrt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) r.bt[1:0]  = 2'b00;
            step(r, 0, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
